spram_arbiter: RTL

//  Two-requester arbiter/sequencer in front of the single-port RAM (spram).

---
 rtl/spram_arbiter_if.sv | 15 +
 rtl/spram_arbiter.sv | 64 ++++++
 2 files changed

// File: rtl/spram_arbiter_if.sv
// spram_arbiter_if: one requester port of the spram arbiter (request handshake plus read response).
interface spram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();
  logic                  valid;
  logic                  ready;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  modport master (output valid, wen, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, wen, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/spram_arbiter.sv
// spram_arbiter: two-port arbiter/sequencer driving a single-port RAM, read data back after 2 cycles.
// Define SPRAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority; round-robin otherwise.
module spram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  spram_arbiter_if.slave        a,
  spram_arbiter_if.slave        b,
  output logic                  mem_me,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  logic grant_a, grant_b, xfer;
  logic rd1, rd1_b, rd2, rd2_b;
  logic [DATA_WIDTH-1:0] hold_a, hold_b;
`ifdef SPRAM_ARB_FIXED_PRIO_EN
  assign grant_a = !reset && a.valid;
`else
  logic last_b;
  assign grant_a = !reset && a.valid && (!b.valid || last_b);
  always_ff @(posedge clk or posedge reset)
    if (reset) last_b <= 1'b1;
    else if (xfer) last_b <= grant_b;
`endif
  assign grant_b = !reset && b.valid && !grant_a;
  assign xfer    = grant_a || grant_b;
  assign a.ready = grant_a;
  assign b.ready = grant_b;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem_me    <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd1       <= 1'b0;
      rd1_b     <= 1'b0;
      rd2       <= 1'b0;
      rd2_b     <= 1'b0;
      hold_a    <= '0;
      hold_b    <= '0;
    end else begin
      mem_me  <= xfer;
      mem_wen <= grant_a ? a.wen : grant_b && b.wen;
      if (xfer) begin
        mem_addr  <= grant_a ? a.addr : b.addr;
        mem_wdata <= grant_a ? a.wdata : b.wdata;
      end
      // tag travels alongside the access so the response finds its port
      rd1   <= grant_a ? !a.wen : grant_b && !b.wen;
      rd1_b <= grant_b;
      rd2   <= rd1;
      rd2_b <= rd1_b;
      if (a.rvalid) hold_a <= mem_rdata;
      if (b.rvalid) hold_b <= mem_rdata;
    end
  assign a.rvalid = rd2 && !rd2_b;
  assign b.rvalid = rd2 && rd2_b;
  assign a.rdata  = a.rvalid ? mem_rdata : hold_a;
  assign b.rdata  = b.rvalid ? mem_rdata : hold_b;
endmodule
